rv16_div_seq: RTL and testbench

- Multi-cycle sequencer for 16-bit unsigned division (restoring algorithm) in the rv16 execute stage.
- Does not contain a subtractor of its own. It drives an external rv16_sub_unit instance through a sub_* port group, issuing one trial subtraction per cycle.
- Sits beside the ALU and serves DIVU/REMU. The pipeline stalls on busy.

---
 rtl/rv16_div_seq.sv | 132 +++++++++++++
 tb/tb_rv16_div_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rv16_div_seq.sv
// Sequencer for 16-bit unsigned restoring division. It uses an external subtract unit through the sub_* ports.
// Optional macro RV16_DIV_EARLY_OUT_EN: when dividend < divisor, finish in a single cycle.
module rv16_div_seq #(
  parameter int DATA  = 16,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DATA-1:0] dividend,
  input  logic [DATA-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [DATA-1:0] quotient,
  output logic [DATA-1:0] remainder,
  output logic            div_by_zero,
  output logic [DATA-1:0] sub_a,
  output logic [DATA-1:0] sub_b,
  output logic            sub_bin,
  input  logic [DATA-1:0] sub_diff,
  input  logic            sub_bout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA - 1);

  state_t           state_q, state_d;
  logic [DATA-1:0]  r_q, r_d;
  logic [DATA-1:0]  q_q, q_d;
  logic [DATA-1:0]  d_q, d_d;
  logic [DATA-1:0]  quot_q, quot_d;
  logic [DATA-1:0]  rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA-1:0]  shift_r;
  logic             ok;

  assign shift_r = {r_q[DATA-2:0], q_q[DATA-1]};
  // A set R MSB means the 17-bit partial remainder beats any divisor; the wrapped difference is still exact.
  assign ok      = r_q[DATA-1] | ~sub_bout;

  // Outside RUN the unit compares the raw operands; the early-out path relies on this.
  assign sub_a   = (state_q == S_RUN) ? shift_r : dividend;
  assign sub_b   = (state_q == S_RUN) ? d_q : divisor;
  assign sub_bin = 1'b0;

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          d_d   = divisor;
          q_d   = dividend;
          r_d   = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
`ifdef RV16_DIV_EARLY_OUT_EN
          else if (sub_bout) begin
            state_d = S_DONE;
            quot_d  = '0;
            rem_d   = dividend;
            dbz_d   = 1'b0;
          end
`endif
          else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (ok) begin
          r_d = sub_diff;
          q_d = {q_q[DATA-2:0], 1'b1};
        end else begin
          r_d = shift_r;
          q_d = {q_q[DATA-2:0], 1'b0};
        end
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          quot_d  = q_d;
          rem_d   = r_d;
          dbz_d   = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rv16_div_seq.sv
// Scoreboard bench for rv16_div_seq: the driver queues reference results, and a monitor checks every done pulse.
module tb_rv16_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_by_zero, sub_bin, sub_bout;
  logic [15:0] quotient, remainder, sub_a, sub_b, sub_diff;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          lat;
    int          busy_n;
    int          t0;
    string       name;
  } exp_t;

  exp_t sb[$];

`ifdef RV16_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  rv16_div_seq dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .sub_a(sub_a), .sub_b(sub_b), .sub_bin(sub_bin),
    .sub_diff(sub_diff), .sub_bout(sub_bout)
  );

  // Stand-in for the external rv16_sub_unit
  assign sub_diff = sub_a - sub_b - {15'd0, sub_bin};
  assign sub_bout = ({1'b0, sub_a} < ({1'b0, sub_b} + {16'd0, sub_bin}));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference results come from plain integer division.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit push, input string name);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.name = name;
      e.t0   = cyc;
      if (b == 16'd0) begin
        e.q = 16'hFFFF; e.r = a; e.z = 1'b1; e.lat = 0;
      end else begin
        e.q = a / b; e.r = a % b; e.z = 1'b0;
        e.lat = (EARLY && a < b) ? 0 : 16;
      end
      e.busy_n = (e.lat == 0) ? 0 : 16;
      sb.push_back(e);
      $display("issue %s: %0d / %0d -> q=%0d r=%0d z=%0b", name, a, b, e.q, e.r, e.z);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d results outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor
  int          busy_cnt = 0;
  bit          bin_bad  = 0;
  bit          hold_bad = 0;
  logic [15:0] last_q   = '0, last_r = '0;
  logic        last_z   = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_cnt = 0; bin_bad = 0; hold_bad = 0;
      last_q = '0; last_r = '0; last_z = 1'b0;
    end else begin
      if (sub_bin !== 1'b0) bin_bad = 1;
      if (busy) begin
        busy_cnt++;
        if (quotient !== last_q || remainder !== last_r || div_by_zero !== last_z) hold_bad = 1;
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending result", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, " quotient"}, 32'(quotient), 32'(e.q));
          chk({e.name, " remainder"}, 32'(remainder), 32'(e.r));
          chk({e.name, " div_by_zero"}, 32'(div_by_zero), 32'(e.z));
          chk({e.name, " latency"}, 32'(cyc - e.t0), 32'(e.lat));
          chk({e.name, " busy_cycles"}, 32'(busy_cnt), 32'(e.busy_n));
          chk({e.name, " busy_in_done"}, 32'(busy), 32'd0);
          chk({e.name, " sub_bin"}, 32'(bin_bad), 32'd0);
          chk({e.name, " hold"}, 32'(hold_bad), 32'd0);
          $display("done %s: q=%0d r=%0d z=%0b busy=%0d", e.name, quotient, remainder, div_by_zero, busy_cnt);
          last_q = e.q; last_r = e.r; last_z = e.z;
        end
        busy_cnt = 0; bin_bad = 0; hold_bad = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; dividend = 16'd0; divisor = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    dividend = 16'h1234; divisor = 16'h0056;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
    chk("idle sub_a", 32'(sub_a), 32'h1234);
    chk("idle sub_b", 32'(sub_b), 32'h0056);
    rst = 1'b0;

    do_op(16'd100, 16'd7, 1, "100/7");          wait_idle("100/7");
    do_op(16'hFFFF, 16'd1, 1, "FFFF/1");        wait_idle("FFFF/1");
    do_op(16'hFFFF, 16'h8000, 1, "FFFF/8000");  wait_idle("FFFF/8000");
    do_op(16'd5, 16'd0, 1, "5/0");              wait_idle("5/0");
    do_op(16'd9, 16'd3, 1, "9/3");              wait_idle("9/3");
    do_op(16'd3, 16'd10, 1, "3/10");            wait_idle("3/10");

    // Starts during RUN and during DONE must be ignored.
    do_op(16'd40000, 16'd9, 1, "40000/9");
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
    repeat (2) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("40000/9");
    repeat (25) @(negedge clk);

    // Reset in the middle of a run
    do_op(16'd40000, 16'd9, 0, "abandoned");
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst quotient", 32'(quotient), 32'd0);
    chk("midrst remainder", 32'(remainder), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_op(16'd50, 16'd5, 1, "50/5");            wait_idle("50/5");

    for (int n = 0; n < 60; n++) begin
      logic [15:0] a, b;
      int sel;
      a   = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)      b = 16'd0;
      else if (sel <= 3) b = 16'($urandom_range(1, 15));
      else if (sel == 4) b = 16'h8000 | 16'($urandom);
      else if (sel == 5) begin b = 16'($urandom) | 16'd1; a = 16'($urandom_range(0, 32'(b) - 1)); end
      else               b = 16'($urandom);
      do_op(a, b, 1, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      wait_idle("rnd");
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
